// File: rtl/gpio_bus_master.sv
// gpio_bus_master: bus initiator for the gpio peripheral register interface.
//
// Takes one command at a time (write, single read, poll-until-match) over a
// valid/ready handshake, runs the corresponding sel/wen/addr/datain bus
// cycles, and returns read data plus status over a valid/ready response.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake (ready only while idle)
//   cmd_op          00 write, 01 read, 10 poll, 11 reserved
//   cmd_addr        target register address
//   cmd_wdata       write data, or match value for poll
//   cmd_mask        poll compare mask
//   rsp_valid/ready response handshake
//   rsp_rdata       read data / last poll sample (0 for write and bad op)
//   rsp_status      00 ok, 01 poll timeout, 10 bad op
//   bus_sel/wen/addr/datain  to peripheral
//   bus_dataout     from peripheral
//   busy            high whenever not idle
module gpio_bus_master #(
  parameter int DW        = 16,
  parameter int AW        = 2,
  parameter int READ_HOLD = 1,
  parameter int POLL_GAP  = 4,
  parameter int POLL_MAX  = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [DW-1:0] cmd_mask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_status,
  output logic          bus_sel,
  output logic          bus_wen,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_datain,
  input  logic [DW-1:0] bus_dataout,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, GAP, RESP} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADOP   = 2'b10;

  localparam int CW = $clog2(POLL_MAX + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int HW = 4;

  localparam logic [CW-1:0] ATT_LAST  = CW'(POLL_MAX);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(READ_HOLD);

  state_t        state;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mask_q;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] attempts;
  logic [CW-1:0] att_next;
  logic          hit;

  assign att_next = attempts + CW'(1);
  assign hit      = ((bus_dataout & mask_q) == (wdata_q & mask_q));

  // Command capture: datapath registers, loaded only on an accepted command.
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid && cmd_ready) begin
      op_q    <= cmd_op;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      mask_q  <= cmd_mask;
    end
  end

  // Control FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      bus_sel    <= 1'b0;
      bus_wen    <= 1'b0;
      bus_addr   <= '0;
      bus_datain <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      attempts   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
            case (cmd_op)
              OP_WRITE: begin
                state      <= WRITE;
                bus_sel    <= 1'b1;
                bus_wen    <= 1'b1;
                bus_addr   <= cmd_addr;
                bus_datain <= cmd_wdata;
              end
              OP_READ, OP_POLL: begin
                state      <= READ;
                bus_sel    <= 1'b1;
                bus_wen    <= 1'b0;
                bus_addr   <= cmd_addr;
                bus_datain <= '0;
                hold_cnt   <= '0;
                attempts   <= '0;
              end
              default: begin
                // Reserved opcode: answer immediately, no bus activity.
                state      <= RESP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_BADOP;
              end
            endcase
          end
        end

        WRITE: begin
          bus_sel    <= 1'b0;
          bus_wen    <= 1'b0;
          bus_addr   <= '0;
          bus_datain <= '0;
          state      <= RESP;
          rsp_valid  <= 1'b1;
        end

        READ: begin
          if (hold_cnt == HOLD_LAST) begin
            // Last cycle of the read window: capture the sample.
            rsp_rdata <= bus_dataout;
            bus_sel   <= 1'b0;
            bus_addr  <= '0;
            if (op_q != OP_POLL) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              attempts <= att_next;
              if (hit) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
              end else if (att_next == ATT_LAST) begin
                state      <= RESP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_TIMEOUT;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= READ;
            bus_sel  <= 1'b1;
            bus_addr <= addr_q;
            hold_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        RESP: begin
          // cmd_ready stays low on the handshake edge, so no back-to-back accept.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          bus_sel   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed testbench for gpio_bus_master (READ_HOLD=1, POLL_GAP=4, POLL_MAX=4).
module tb_gpio_bus_master;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] cmd_mask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic          bus_sel;
  logic          bus_wen;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_datain;
  logic [DW-1:0] bus_dataout;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_bus_master #(
    .DW(DW), .AW(AW), .READ_HOLD(1), .POLL_GAP(4), .POLL_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .bus_sel(bus_sel), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_datain(bus_datain), .bus_dataout(bus_dataout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one edge; IDLE is assumed.
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] m);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_mask  = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (bus_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %0b want 0", bus_sel); end
    n_checks++; if (bus_wen !== 1'b0 || bus_addr !== '0 || bus_datain !== '0) begin n_fail++; $display("FAIL reset_bus got wen=%0b addr=%0h din=%0h want 0", bus_wen, bus_addr, bus_datain); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_status !== 2'b00) begin n_fail++; $display("FAIL reset_rsp got v=%0b d=%0h s=%0h want 0", rsp_valid, rsp_rdata, rsp_status); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready got rdy=%0b busy=%0b want 1/0", cmd_ready, busy); end
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send_cmd(2'b00, a, d, 16'hFFFF);
    // cycle 1: the single write strobe
    n_checks++; if (bus_sel !== 1'b1 || bus_wen !== 1'b1) begin n_fail++; $display("FAIL wr_strobe got sel=%0b wen=%0b want 1/1", bus_sel, bus_wen); end
    n_checks++; if (bus_addr !== a || bus_datain !== d) begin n_fail++; $display("FAIL wr_bus got addr=%0h din=%0h want %0h/%0h", bus_addr, bus_datain, a, d); end
    n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_busy got rdy=%0b busy=%0b v=%0b want 0/1/0", cmd_ready, busy, rsp_valid); end
    tick();
    // cycle 2: response, bus released
    n_checks++; if (bus_sel !== 1'b0 || bus_wen !== 1'b0 || bus_datain !== '0) begin n_fail++; $display("FAIL wr_release got sel=%0b wen=%0b din=%0h want 0", bus_sel, bus_wen, bus_datain); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== '0) begin n_fail++; $display("FAIL wr_rsp got v=%0b s=%0h d=%0h want 1/0/0", rsp_valid, rsp_status, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_done got v=%0b rdy=%0b busy=%0b want 0/1/0", rsp_valid, cmd_ready, busy); end
  endtask

  task automatic test_read();
    send_cmd(2'b01, 2'd2, 16'h0000, 16'h0000);
    bus_dataout = 16'h1234;
    n_checks++; if (bus_sel !== 1'b1 || bus_wen !== 1'b0 || bus_addr !== 2'd2 || bus_datain !== '0) begin n_fail++; $display("FAIL rd_cyc1 got sel=%0b wen=%0b addr=%0h din=%0h want 1/0/2/0", bus_sel, bus_wen, bus_addr, bus_datain); end
    tick();
    bus_dataout = 16'h0002;
    n_checks++; if (bus_sel !== 1'b1 || bus_wen !== 1'b0 || bus_addr !== 2'd2 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_cyc2 got sel=%0b wen=%0b addr=%0h v=%0b want 1/0/2/0", bus_sel, bus_wen, bus_addr, rsp_valid); end
    tick();
    bus_dataout = 16'hBEEF;
    n_checks++; if (bus_sel !== 1'b0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp got sel=%0b v=%0b want 0/1", bus_sel, rsp_valid); end
    n_checks++; if (rsp_rdata !== 16'h0002 || rsp_status !== 2'b00) begin n_fail++; $display("FAIL rd_data got d=%0h s=%0h want 0002/0", rsp_rdata, rsp_status); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_done got v=%0b rdy=%0b want 0/1", rsp_valid, cmd_ready); end
  endtask

  // Poll with match on bit0; bit0 rises for the 3rd read window (cycles 13-14).
  task automatic test_poll_match();
    int windows;
    int sel_errs;
    logic prev_sel;
    logic exp_sel;
    windows  = 0;
    sel_errs = 0;
    prev_sel = 1'b0;
    bus_dataout = 16'hA500;
    send_cmd(2'b10, 2'd2, 16'h0001, 16'h0001);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      bus_dataout = (cyc >= 13) ? 16'hA501 : 16'hA500;
      exp_sel = (cyc % 6 == 1) || (cyc % 6 == 2);
      if (bus_sel !== exp_sel || rsp_valid !== 1'b0) sel_errs++;
      if (bus_sel === 1'b1 && prev_sel === 1'b0) windows++;
      prev_sel = bus_sel;
      tick();
    end
    n_checks++; if (sel_errs != 0) begin n_fail++; $display("FAIL poll_timing got %0d bad cycles want 0", sel_errs); end
    n_checks++; if (windows != 3) begin n_fail++; $display("FAIL poll_windows got %0d want 3", windows); end
    n_checks++; if (rsp_valid !== 1'b1 || bus_sel !== 1'b0) begin n_fail++; $display("FAIL poll_rsp got v=%0b sel=%0b want 1/0", rsp_valid, bus_sel); end
    n_checks++; if (rsp_rdata !== 16'hA501 || rsp_status !== 2'b00) begin n_fail++; $display("FAIL poll_data got d=%0h s=%0h want a501/0", rsp_rdata, rsp_status); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Poll that never matches: 4 windows, then timeout with the last sample.
  task automatic test_poll_timeout();
    int windows;
    int sel_errs;
    logic prev_sel;
    logic exp_sel;
    windows  = 0;
    sel_errs = 0;
    prev_sel = 1'b0;
    send_cmd(2'b10, 2'd1, 16'h0001, 16'h0001);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bus_dataout = 16'(((cyc - 1) / 6 + 1) * 16'h0100);
      exp_sel = (cyc % 6 == 1) || (cyc % 6 == 2);
      if (bus_sel !== exp_sel || rsp_valid !== 1'b0) sel_errs++;
      if (bus_sel === 1'b1 && prev_sel === 1'b0) windows++;
      prev_sel = bus_sel;
      tick();
    end
    n_checks++; if (sel_errs != 0) begin n_fail++; $display("FAIL tmo_timing got %0d bad cycles want 0", sel_errs); end
    n_checks++; if (windows != 4) begin n_fail++; $display("FAIL tmo_windows got %0d want 4", windows); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_rdata !== 16'h0400) begin n_fail++; $display("FAIL tmo_rsp got v=%0b s=%0h d=%0h want 1/1/0400", rsp_valid, rsp_status, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Zero mask matches on the very first read.
  task automatic test_mask_zero();
    bus_dataout = 16'h00F0;
    send_cmd(2'b10, 2'd3, 16'h0001, 16'h0000);
    tick();
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 16'h00F0) begin n_fail++; $display("FAIL mask0_rsp got v=%0b s=%0h d=%0h want 1/0/00f0", rsp_valid, rsp_status, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Reserved op, response back-pressure and ignored commands while busy.
  task automatic test_bad_op();
    int errs;
    errs = 0;
    send_cmd(2'b11, 2'd3, 16'h7777, 16'h0000);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_addr  = 2'd1;
    cmd_wdata = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_rdata !== '0 ||
          cmd_ready !== 1'b0 || bus_sel !== 1'b0 || busy !== 1'b1) errs++;
      tick();
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL badop_hold got %0d bad cycles want 0", errs); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b10) begin n_fail++; $display("FAIL badop_rsp got v=%0b s=%0h want 1/2", rsp_valid, rsp_status); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bus_sel !== 1'b0) begin n_fail++; $display("FAIL badop_done got v=%0b rdy=%0b sel=%0b want 0/1/0", rsp_valid, cmd_ready, bus_sel); end
    cmd_valid = 1'b0;
    tick();
    n_checks++; if (bus_sel !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL badop_noaccept got sel=%0b busy=%0b want 0/0", bus_sel, busy); end
  endtask

  task automatic test_reset_mid();
    // Reset in the gap of a poll.
    bus_dataout = 16'h0000;
    send_cmd(2'b10, 2'd2, 16'h0001, 16'h0001);
    tick(); tick(); tick();
    n_checks++; if (bus_sel !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_state got sel=%0b busy=%0b want 0/1", bus_sel, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus_sel !== 1'b0 || bus_addr !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_gap got sel=%0b addr=%0h v=%0b busy=%0b rdy=%0b want 0/0/0/0/1", bus_sel, bus_addr, rsp_valid, busy, cmd_ready); end
    tick(); tick();
    n_checks++; if (bus_sel !== 1'b0) begin n_fail++; $display("FAIL rst_gap_quiet got sel=%0b want 0", bus_sel); end
    test_write(2'd3, 16'h1357);
    // Reset while a response is pending.
    send_cmd(2'b11, 2'd0, 16'h0000, 16'h0000);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL resp_pending got v=%0b want 1", rsp_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_status !== 2'b00 || rsp_rdata !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 || bus_sel !== 1'b0) begin n_fail++; $display("FAIL rst_resp got v=%0b s=%0h d=%0h busy=%0b rdy=%0b sel=%0b", rsp_valid, rsp_status, rsp_rdata, busy, cmd_ready, bus_sel); end
    test_write(2'd1, 16'h00A5);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    cmd_mask    = '0;
    rsp_ready   = 1'b0;
    bus_dataout = '0;
    test_reset();
    test_write(2'd0, 16'hFFFC);
    test_read();
    test_poll_match();
    test_poll_timeout();
    test_mask_zero();
    test_bad_op();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
